// File: rtl/ctz_serial_gen.sv
// ctz_serial_gen: turns a trailing-zero count k into the isolated-LSB word
// (bit k set, or all-zero for k == DATA_WIDTH) and streams it LSB-first,
// one bit per accepted beat, with a parallel copy on word_out.
// Ports: clk/reset (sync, active-high); cnt_in/cnt_valid/cnt_ready count input;
//        dout/dout_valid/dout_ready/dout_last serial output; word_out parallel
//        word; sat_err one-cycle pulse when the accepted count was above DATA_WIDTH.
module ctz_serial_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CW-1:0]         cnt_in,
  input  logic                  cnt_valid,
  output logic                  cnt_ready,
  output logic                  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  sat_err
);

  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   k_r;
  logic [CW-1:0]   k_sat;
  logic            accept;

  // Out-of-range counts collapse onto the all-zero frame.
  assign k_sat = (cnt_in > CW'(DATA_WIDTH)) ? CW'(DATA_WIDTH) : cnt_in;

  assign dout_valid = (state == SHIFT);
  assign dout_last  = (state == SHIFT) && (idx == IW'(DATA_WIDTH - 1));
  // idx never reaches DATA_WIDTH, so a saturated k_r yields all-zero beats.
  assign dout       = (state == SHIFT) && (CW'(idx) == k_r);

  // In SHIFT a new count is only taken on the final accepted beat, which lets
  // the next frame start with no bubble. Held low while reset is asserted.
  assign cnt_ready = !reset && ((state == IDLE) || (dout_last && dout_ready));
  assign accept    = cnt_valid && cnt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      k_r      <= '0;
      word_out <= '0;
      sat_err  <= 1'b0;
    end else begin
      sat_err <= 1'b0;
      if (accept) begin
        k_r      <= k_sat;
        word_out <= (k_sat == CW'(DATA_WIDTH)) ? '0
                    : ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << k_sat);
        idx      <= '0;
        state    <= SHIFT;
        sat_err  <= (cnt_in > CW'(DATA_WIDTH));
      end else if (state == SHIFT && dout_ready) begin
        if (dout_last) begin
          state <= IDLE;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: doc/ctz_serial_gen.md
# ctz_serial_gen

Serial trailing-zero pattern generator: the transmit-side inverse of the count-trailing-zeros block. It accepts a trailing-zero count `k` on a valid/ready handshake and regenerates the isolated-LSB word (bit `k` set, all other bits 0; all-zero when `k == DATA_WIDTH`). It streams that word out LSB-first, one bit per beat, under output backpressure, and also presents it in parallel. Feeding the parallel word back through the trailing-zero counter returns `k`, which makes the block the round-trip partner for that counter on serial links.

## Interface
- `DATA_WIDTH`, default 32: word width in bits; must be ≥ 2.
- `CW`, default `$clog2(DATA_WIDTH)+1`: count width, the same width the trailing-zero counter uses for its output. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cnt_in`  in  CW  trailing-zero count `k`; legal range 0..DATA_WIDTH.
- `cnt_valid`  in  1  `cnt_in` is valid.
- `cnt_ready`  out  1  block can accept a count this cycle.
- `dout`  out  1  serial bit, LSB first.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  downstream accepts `dout` this cycle.
- `dout_last`  out  1  current beat is bit `DATA_WIDTH-1` of the word.
- `word_out`  out  DATA_WIDTH  parallel copy of the word currently being sent; holds its value after the frame ends.
- `sat_err`  out  1  one-cycle pulse: the last accepted count exceeded DATA_WIDTH.

## Operation
- The FSM has two states: IDLE and SHIFT. Registers are `k_r` (CW bits), `idx` (`$clog2(DATA_WIDTH)` bits), `word_out` and `sat_err`.
- A count is accepted when `cnt_valid && cnt_ready`. On acceptance:
  - `k_r <= min(cnt_in, DATA_WIDTH)`.
  - `word_out <= (k_sat == DATA_WIDTH) ? 0 : (1 << k_sat)`.
  - `idx <= 0`; state goes to SHIFT.
  - `sat_err <= (cnt_in > DATA_WIDTH)`.
- `sat_err` is 0 in every cycle that does not follow an acceptance.
- IDLE: `dout_valid = 0`, `dout = 0`, `dout_last = 0`, `cnt_ready = 1`.
- SHIFT outputs:
  - `dout_valid = 1`.
  - `dout = (idx == k_r)`; this is never true when `k_r == DATA_WIDTH`.
  - `dout_last = (idx == DATA_WIDTH-1)`.
- SHIFT on a beat (`dout_valid && dout_ready`):
  - If not last: `idx <= idx + 1`.
  - If last and no new count is accepted in the same cycle: state goes to IDLE.
- Back-to-back frames: in SHIFT, `cnt_ready = dout_last && dout_ready`. This is combinational from `dout_ready` and is the only such path. If a count is accepted on the last beat, the new frame loads and SHIFT continues with `idx = 0`, with no bubble.
- Backpressure: while `dout_valid && !dout_ready`, `dout`, `dout_last`, `idx`, `k_r` and `word_out` hold.
- `cnt_in` values above DATA_WIDTH saturate to DATA_WIDTH, producing an all-zero frame, and pulse `sat_err`.
- Reset mid-frame: the frame aborts immediately. No further beats are produced, and the partial frame is not resumed.

## Timing
- Reset values:
  - State IDLE; `idx`, `k_r`, `word_out` and `sat_err` are 0.
  - `dout_valid`, `dout` and `dout_last` are 0.
  - `cnt_ready` is 0 while `reset` is high, and 1 in the first cycle after reset.
- Latency: count accepted at edge N → first beat (bit 0) valid in cycle N+1.
- With `dout_ready` held high:
  - The last beat is in cycle N+DATA_WIDTH.
  - Sustained throughput is one count per DATA_WIDTH cycles.
- `word_out` and `sat_err` update at the acceptance edge and are visible in cycle N+1.
- `cnt_in` is sampled only at the acceptance edge.

## Test plan
- DATA_WIDTH=8, reset then `cnt_in=3` accepted, `dout_ready=1` → beats 0,0,0,1,0,0,0,0; `dout_last` only on the 8th beat; `word_out=8'h08`; `sat_err=0`.
- `cnt_in=0` → `word_out=8'h01`, first beat is 1. `cnt_in=8` → `word_out=8'h00`, all 8 beats 0.
- `cnt_in=13` → `sat_err` high for exactly one cycle; output identical to `cnt_in=8`.
- Counts 5 then 2 presented back-to-back with `cnt_valid` held → second count accepted on the first frame's last beat; 16 consecutive valid beats with no gap; `word_out` goes 8'h20 then 8'h04.
- `cnt_in=6`, then `dout_ready` toggled 1,0,0,1,… → every beat is held stable while stalled, the sequence is unchanged, and `cnt_ready` stays 0 until the last beat is accepted.
- `reset` asserted on the 4th beat of `cnt_in=1` → next cycle `dout_valid=0` and `word_out=0`. A new count of 7 afterwards → clean frame ending in bit 7 = 1. Round-trip: for every k in 0..8, `word_out` fed into the trailing-zero counter returns k.
